dlx_inst_encoder: RTL

Instruction encoder and program loader for the DLX pipeline. It accepts decoded instruction descriptions (opcode, function, register fields, immediate) over a valid/ready handshake and packs them into 32-bit R/I/J-format words. It buffers the words in a small FIFO and writes them to instruction memory at consecutive word addresses. This is the inverse of the control decoder, used by bring-up benches and the boot loader to build programs from field-level descriptions.

---
 rtl/dlx_isa_pkg.sv | 40 ++++
 rtl/dlx_sync_fifo.sv | 47 ++++
 rtl/dlx_inst_encoder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dlx_isa_pkg.sv
// DLX ISA definitions shared by the instruction encoder and the control decoder.
package dlx_isa_pkg;

  // Field widths of the 32-bit instruction word (bit 0 is the MSB)
  localparam int INST_W   = 32;
  localparam int OPCODE_W = 6;
  localparam int REG_W    = 5;
  localparam int FUNC_W   = 6;
  localparam int IMM_J_W  = 26;
  localparam int IMM_I_W  = 16;

  // Opcodes that anchor the class map
  localparam logic [0:OPCODE_W-1] OP_RTYPE        = 6'h00;
  localparam logic [0:OPCODE_W-1] OP_FPRTYPE      = 6'h01;
  localparam logic [0:OPCODE_W-1] OP_J            = 6'h02;
  localparam logic [0:OPCODE_W-1] OP_JAL          = 6'h03;
  localparam logic [0:OPCODE_W-1] OP_RFE          = 6'h10;
  localparam logic [0:OPCODE_W-1] OP_TRAP         = 6'h11;
  localparam logic [0:OPCODE_W-1] OP_ILLEGAL_BASE = 6'h30;

  // Function codes
  localparam logic [0:FUNC_W-1] FN_ADD = 6'h20;

  typedef enum logic [1:0] {CLS_R, CLS_I, CLS_J, CLS_ILLEGAL} inst_class_t;

  // Map an opcode to its instruction format; everything from 0x30 up is unassigned.
  function automatic inst_class_t classify(input logic [0:OPCODE_W-1] op);
    inst_class_t c;
    if (op == OP_RTYPE || op == OP_FPRTYPE)
      c = CLS_R;
    else if (op == OP_J || op == OP_JAL || op == OP_RFE || op == OP_TRAP)
      c = CLS_J;
    else if (op >= OP_ILLEGAL_BASE)
      c = CLS_ILLEGAL;
    else
      c = CLS_I;
    return c;
  endfunction

endpackage

// File: rtl/dlx_sync_fifo.sv
// Synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module dlx_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push,
  input  logic [0:DATA_W-1]        wdata,
  input  logic                     pop,
  output logic [0:DATA_W-1]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic [0:DATA_W-1]   mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointer update; a clear discards everything queued
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/dlx_inst_encoder.sv
// Packs field-level instruction descriptors into DLX words and streams them to imem.
module dlx_inst_encoder
  import dlx_isa_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [0:31] BASE_ADDR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          restart,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [0:5]    req_opcode,
  input  logic [0:5]    req_func,
  input  logic [0:4]    req_rs1,
  input  logic [0:4]    req_rs2,
  input  logic [0:4]    req_rd,
  input  logic [0:25]   req_imm,
  output logic          imem_we,
  input  logic          imem_ready,
  output logic [0:31]   imem_addr,
  output logic [0:31]   imem_wdata,
  output logic          done,
  output logic          err,
  output logic [0:7]    err_count,
  output logic [0:15]   word_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  inst_class_t        cls;
  logic [0:INST_W-1]  word;
  logic [CW-1:0]      count;
  logic               clr;
  logic               full;
  logic               empty;
  logic               accept;
  logic               push;
  logic               pop;

  function automatic logic [0:INST_W-1] pack_inst(
    input inst_class_t           c,
    input logic [0:OPCODE_W-1]   op,
    input logic [0:FUNC_W-1]     fn,
    input logic [0:REG_W-1]      s1,
    input logic [0:REG_W-1]      s2,
    input logic [0:REG_W-1]      d,
    input logic [0:IMM_J_W-1]    imm
  );
    logic [0:INST_W-1] w;
    w = '0;
    case (c)
      CLS_R:   w = {op, s1, s2, d, {REG_W{1'b0}}, fn};
      CLS_I:   w = {op, s1, d, imm[IMM_J_W-IMM_I_W:IMM_J_W-1]};
      CLS_J:   w = {op, imm};
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic logic [0:7] sat_inc8(input logic [0:7] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign clr     = reset | restart;
  assign cls     = classify(req_opcode);
  assign word    = pack_inst(cls, req_opcode, req_func, req_rs1, req_rs2, req_rd, req_imm);
  assign accept  = req_valid & req_ready;
  assign push    = accept & (cls != CLS_ILLEGAL);
  assign imem_we = ~empty;
  assign pop     = imem_we & imem_ready;

  // Request to memory boundary: every word is registered in the FIFO
  dlx_sync_fifo #(
    .DATA_W (INST_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (push),
    .wdata (word),
    .pop   (pop),
    .rdata (imem_wdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Program-phase state register
  always_ff @(posedge clk) begin
    if (clr)
      state <= ST_RUN;
    else
      state <= state_nxt;
  end

  // Phase transitions: a TRAP closes the program, then the FIFO drains
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    done      = 1'b0;
    case (state)
      ST_RUN: begin
        req_ready = ~full;
        if (accept && req_opcode == OP_TRAP)
          state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && count == CW'(1))
          state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Write address, word and error bookkeeping
  always_ff @(posedge clk) begin
    if (clr) begin
      imem_addr  <= BASE_ADDR;
      word_count <= '0;
      err        <= 1'b0;
      err_count  <= '0;
    end else begin
      if (pop) begin
        imem_addr  <= imem_addr + 32'd4;
        word_count <= word_count + 16'd1;
      end
      if (accept && cls == CLS_ILLEGAL) begin
        err       <= 1'b1;
        err_count <= sat_inc8(err_count);
      end
    end
  end

endmodule
